instr_mem_loader: RTL and testbench
===================================

// Module: instr_mem_loader
// PURPOSE
//  Write-side companion to the byte-addressed, little-endian instruction memory.
//  - Accepts a framed byte stream over a valid/ready handshake and emits one byte write per accepted payload byte.
//  - Stream comes from a host/UART/testbench.
//  - Frame: 4-byte little-endian length, payload bytes, 1-byte XOR checksum.
//  - Holds the CPU (cpu_hold) while loading so fetch never sees a partial image.
// PARAMETERS
//  ADDR_WIDTH  16  byte-address width of the target memory (2**ADDR_WIDTH bytes)
//  BASE_ADDR   0   byte address at which payload byte 0 is written
// PORTS
//  clk         in   1           rising-edge clock
//  rst         in   1           synchronous, active-high reset
//  start       in   1           begin a load session (sampled in IDLE/ERR only)
//  byte_valid  in   1           stream byte present
//  byte_data   in   8           stream byte
//  byte_ready  out  1           loader accepts byte this cycle
//  mem_we      out  1           byte write strobe to instruction memory
//  mem_addr    out  ADDR_WIDTH  byte write address
//  mem_wdata   out  8           byte write data
//  cpu_hold    out  1           keep CPU PC/pipeline in reset while high
//  busy        out  1           session in progress (HDR/DATA/CSUM)
//  done        out  1           one-cycle pulse: frame loaded, checksum good
//  error       out  1           sticky: bad length or checksum; cleared by start/rst
// BEHAVIOUR
//  - Reset: state IDLE. All outputs 0. Counters, length and checksum cleared.
//  - Handshake: byte accepted iff byte_valid && byte_ready.
//    - byte_ready = 1 in HDR, DATA and CSUM, else 0. Combinational from state only; no dependence on byte_valid.
//    - Throughput: 1 byte/cycle.
//  - States and transitions:
//    - IDLE: start -> HDR. cpu_hold<=1, hdr_cnt<=0, csum<=0.
//    - HDR: each accepted byte shifts into len[8*hdr_cnt +: 8]. On the 4th byte:
//      - BASE_ADDR + len > 2**ADDR_WIDTH (33-bit compare) -> ERR.
//      - else len == 0 -> CSUM.
//      - else -> DATA, byte_cnt<=0.
//    - DATA: each accepted byte -> next cycle mem_we=1, mem_addr=BASE_ADDR+byte_cnt (mod 2**ADDR_WIDTH), mem_wdata=byte. csum ^= byte, byte_cnt++.
//      - Accepting byte len-1 -> CSUM.
//    - CSUM: accepted byte == csum -> IDLE with done=1 for one cycle. Mismatch -> ERR.
//    - ERR: error=1, cpu_hold=0, byte_ready=0. start -> HDR (error<=0, cpu_hold<=1).
//  - Latency: byte accepted at edge N -> mem_we high for cycle N+1 only. mem_addr/mem_wdata are registered and hold their last value when mem_we=0.
//  - cpu_hold: rises the cycle after start is accepted. Falls the same cycle done pulses or ERR is entered.
//  - busy: high exactly in HDR/DATA/CSUM.
//  - Boundaries:
//    - start while busy: ignored.
//    - start with byte_valid in the same cycle: the byte is not accepted (ready=0 in IDLE).
//    - Stalls (byte_valid=0): hold all state; no mem_we.
//    - Exact fill (BASE_ADDR+len == 2**ADDR_WIDTH): legal. The last write goes to address 2**ADDR_WIDTH-1.
//    - Mid-operation rst: next cycle IDLE, all outputs 0. Bytes already written are not rolled back.
// STRUCTURE
//  - Package loader_pkg holds:
//    - typedef enum logic [2:0] {IDLE, HDR, DATA, CSUM, ERR} loader_state_t
//    - localparam HDR_BYTES = 4
//    - localparam CSUM_INIT = 8'h00
//  - Single module, no sub-module. One registered FSM, one counter (ADDR_WIDTH+1 bits), a 32-bit len register, an 8-bit XOR accumulator and a registered write port.
// TESTING
//  - Reset: rst=1 for 2 cycles with byte_valid=1 -> every output 0, no write.
//  - Good frame, BASE_ADDR=0: start; 08 00 00 00; 13 05 a0 00 93 05 b0 00; checksum 90.
//    -> 8 writes at addr 0..7 with those bytes, each 1 cycle after its accept.
//    -> done pulses once, then cpu_hold falls.
//  - Bad checksum: same frame ending in 91 -> no done, error=1, cpu_hold=0, byte_ready=0. Then start -> error=0, busy=1.
//  - Oversize: header 01 00 01 00 (len=0x10001) -> ERR right after the 4th header byte, zero mem_we pulses.
//  - Zero length and backpressure:
//    - Header 00 00 00 00 then checksum 00 -> done, no writes.
//    - 4-byte frame with byte_valid toggled 1/0 -> writes only on handshakes, addresses 0..3 contiguous.
//  - Reset mid-DATA after 3 payload bytes -> IDLE next cycle, all outputs 0. A fresh good frame then loads correctly.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory stream loader.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        CSUM,
        ERR
    } loader_state_t;

    // Frame header is a 4-byte little-endian payload length.
    localparam int HDR_BYTES = 4;
    localparam int HDR_CNT_W = $clog2(HDR_BYTES);

    // XOR checksum seed at the start of every frame.
    localparam logic [7:0] CSUM_INIT = 8'h00;

    // A session is active (stream accepted, CPU held) in these states.
    function automatic logic is_active(input loader_state_t st);
        return (st == HDR) || (st == DATA) || (st == CSUM);
    endfunction

endpackage

// File: rtl/instr_mem_loader.sv
// Framed byte-stream loader: parses [len32 LE][payload][xor8], writes the
// payload byte-by-byte into instruction memory and holds the CPU meanwhile.
module instr_mem_loader
    import loader_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    // Payload counter is one bit wider than the address so an exact fill
    // of the whole memory can be counted without wrapping.
    localparam int          CNT_W     = ADDR_WIDTH + 1;
    localparam logic [32:0] MEM_BYTES = 33'd1 << ADDR_WIDTH;
    localparam logic [32:0] BASE_EXT  = {{(33 - ADDR_WIDTH){1'b0}}, BASE_ADDR};

    loader_state_t          state_reg,     state_next;
    logic [HDR_CNT_W-1:0]   hdr_cnt_reg,   hdr_cnt_next;
    logic [CNT_W-1:0]       byte_cnt_reg,  byte_cnt_next;
    logic [31:0]            len_reg,       len_next;
    logic [7:0]             csum_reg,      csum_next;
    logic                   mem_we_reg,    mem_we_next;
    logic [ADDR_WIDTH-1:0]  mem_addr_reg,  mem_addr_next;
    logic [7:0]             mem_wdata_reg, mem_wdata_next;
    logic                   done_reg,      done_next;

    logic                   accept;
    logic [32:0]            end_addr;
    logic                   last_payload;

    // Ready depends on state only, never on byte_valid.
    assign byte_ready = is_active(state_reg);
    assign busy       = is_active(state_reg);
    assign cpu_hold   = is_active(state_reg);
    assign error      = (state_reg == ERR);
    assign accept     = byte_valid && byte_ready;

    assign mem_we     = mem_we_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_wdata  = mem_wdata_reg;
    assign done       = done_reg;

    // One past the last address the frame would touch, in 33 bits so that
    // BASE_ADDR + len cannot overflow before the range check.
    assign end_addr     = BASE_EXT + {1'b0, len_next};
    assign last_payload = (32'(byte_cnt_reg) == (len_reg - 32'd1));

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            hdr_cnt_reg   <= '0;
            byte_cnt_reg  <= '0;
            len_reg       <= '0;
            csum_reg      <= CSUM_INIT;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            hdr_cnt_reg   <= hdr_cnt_next;
            byte_cnt_reg  <= byte_cnt_next;
            len_reg       <= len_next;
            csum_reg      <= csum_next;
            mem_we_reg    <= mem_we_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            done_reg      <= done_next;
        end
    end

    // Next-state and datapath updates; everything holds unless a byte is
    // accepted or a session is started.
    always_comb begin
        state_next     = state_reg;
        hdr_cnt_next   = hdr_cnt_reg;
        byte_cnt_next  = byte_cnt_reg;
        len_next       = len_reg;
        csum_next      = csum_reg;
        mem_we_next    = 1'b0;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        done_next      = 1'b0;

        case (state_reg)
            IDLE, ERR: begin
                if (start) begin
                    state_next    = HDR;
                    hdr_cnt_next  = '0;
                    byte_cnt_next = '0;
                    len_next      = '0;
                    csum_next     = CSUM_INIT;
                end
            end

            HDR: begin
                if (accept) begin
                    len_next[8*hdr_cnt_reg +: 8] = byte_data;
                    hdr_cnt_next = hdr_cnt_reg + 1'b1;
                    if (hdr_cnt_reg == HDR_CNT_W'(HDR_BYTES - 1)) begin
                        byte_cnt_next = '0;
                        if (end_addr > MEM_BYTES) begin
                            state_next = ERR;
                        end else if (len_next == 32'd0) begin
                            state_next = CSUM;
                        end else begin
                            state_next = DATA;
                        end
                    end
                end
            end

            DATA: begin
                if (accept) begin
                    mem_we_next    = 1'b1;
                    mem_addr_next  = BASE_ADDR + byte_cnt_reg[ADDR_WIDTH-1:0];
                    mem_wdata_next = byte_data;
                    csum_next      = csum_reg ^ byte_data;
                    byte_cnt_next  = byte_cnt_reg + 1'b1;
                    if (last_payload) begin
                        state_next = CSUM;
                    end
                end
            end

            CSUM: begin
                if (accept) begin
                    if (byte_data == csum_reg) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        state_next = ERR;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: good frame, bad checksum, oversize,
// zero length, backpressure and mid-frame reset.
module tb_instr_mem_loader;

    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          cpu_hold;
    logic          busy;
    logic          done;
    logic          error;

    int tests = 0;
    int fails = 0;
    int wr_n  = 0;
    int done_n = 0;

    instr_mem_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(16'h0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    // Count write strobes and done pulses away from the active edge.
    always @(negedge clk) begin
        if (mem_we) wr_n = wr_n + 1;
        if (done)   done_n = done_n + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests = tests + 1;
        assert (obs === exp) else begin
            fails = fails + 1;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_data  = b;
        tick();
        byte_valid = 1'b0;
        $display("[TB] byte %h: we=%b addr=%h wdata=%h busy=%b done=%b err=%b",
                 b, mem_we, mem_addr, mem_wdata, busy, done, error);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_hdr(input logic [31:0] len);
        for (int i = 0; i < 4; i++) send(len[8*i +: 8]);
    endtask

    logic [7:0] prog [8];
    int         wr_base;

    initial begin
        prog[0] = 8'h13; prog[1] = 8'h05; prog[2] = 8'ha0; prog[3] = 8'h00;
        prog[4] = 8'h93; prog[5] = 8'h05; prog[6] = 8'hb0; prog[7] = 8'h00;

        // Reset with a byte offered: nothing may be accepted or written.
        rst = 1'b1; start = 1'b0; byte_valid = 1'b1; byte_data = 8'h5a;
        tick(); tick();
        chk("rst_outputs", {26'd0, byte_ready, mem_we, cpu_hold, busy, done, error}, 32'd0);
        chk("rst_addr", {16'd0, mem_addr}, 32'd0);
        chk("rst_wdata", {24'd0, mem_wdata}, 32'd0);
        rst = 1'b0; byte_valid = 1'b0;
        tick();
        chk("rst_no_writes", wr_n, 0);

        // Good frame; start offered together with a byte that must be ignored.
        byte_valid = 1'b1; byte_data = 8'hff;
        do_start();
        byte_valid = 1'b0;
        chk("start_busy", {busy, cpu_hold, byte_ready}, 3'b111);
        send_hdr(32'd8);
        chk("hdr_no_write", wr_n, 0);
        for (int i = 0; i < 8; i++) begin
            send(prog[i]);
            chk($sformatf("good_wr%0d", i), {mem_we, 7'd0, mem_wdata, mem_addr}, {1'b1, 7'd0, prog[i], 16'(i)});
        end
        send(8'h90);
        chk("good_done", {done, cpu_hold, busy, error, mem_we}, 5'b10000);
        tick();
        chk("good_done_pulse", done, 1'b0);
        chk("good_wr_count", wr_n, 8);
        chk("good_addr_hold", {mem_wdata, mem_addr}, {8'h00, 16'h0007});

        // Same frame with a bad checksum.
        wr_base = wr_n;
        do_start();
        send_hdr(32'd8);
        for (int i = 0; i < 8; i++) send(prog[i]);
        send(8'h91);
        chk("bad_csum_state", {done, error, cpu_hold, byte_ready, busy}, 5'b01000);
        tick();
        chk("bad_csum_sticky", error, 1'b1);
        chk("bad_csum_no_done", done_n, 1);
        do_start();
        chk("restart_from_err", {error, busy, cpu_hold}, 3'b011);

        // Oversize header: 0x10001 bytes does not fit 64 KiB.
        wr_base = wr_n;
        send(8'h01); send(8'h00); send(8'h01);
        chk("oversize_mid_hdr", {busy, error}, 2'b10);
        send(8'h00);
        chk("oversize_err", {error, busy, cpu_hold, byte_ready}, 4'b1000);
        send(8'h13);
        chk("oversize_no_writes", wr_n - wr_base, 0);

        // Zero-length frame: header then checksum 00.
        do_start();
        send_hdr(32'd0);
        chk("zero_len_csum", {busy, error}, 2'b10);
        send(8'h00);
        chk("zero_len_done", {done, error, busy}, 3'b100);
        chk("zero_len_no_writes", wr_n - wr_base, 0);

        // Backpressure: stall cycle after every payload byte, stray start mid-frame.
        do_start();
        send_hdr(32'd4);
        prog[0] = 8'haa; prog[1] = 8'hbb; prog[2] = 8'hcc; prog[3] = 8'hdd;
        for (int i = 0; i < 4; i++) begin
            send(prog[i]);
            chk($sformatf("bp_wr%0d", i), {mem_we, 7'd0, mem_wdata, mem_addr}, {1'b1, 7'd0, prog[i], 16'(i)});
            start = (i == 1);
            tick();
            start = 1'b0;
            chk($sformatf("bp_stall%0d", i), {mem_we, busy}, 2'b01);
        end
        send(8'h00);
        chk("bp_done", {done, error}, 2'b10);
        chk("bp_wr_count", wr_n - wr_base, 4);

        // Reset after three payload bytes, then a fresh good frame.
        prog[0] = 8'h13; prog[1] = 8'h05; prog[2] = 8'ha0; prog[3] = 8'h00;
        do_start();
        send_hdr(32'd8);
        for (int i = 0; i < 3; i++) send(prog[i]);
        rst = 1'b1;
        tick();
        chk("midrst_outputs", {26'd0, byte_ready, mem_we, cpu_hold, busy, done, error}, 32'd0);
        chk("midrst_addr", {8'd0, mem_wdata, mem_addr}, 32'd0);
        rst = 1'b0;
        tick();
        wr_base = wr_n;
        do_start();
        send_hdr(32'd8);
        for (int i = 0; i < 8; i++) begin
            send(prog[i]);
            chk($sformatf("reload_wr%0d", i), {mem_we, 7'd0, mem_wdata, mem_addr}, {1'b1, 7'd0, prog[i], 16'(i)});
        end
        send(8'h90);
        chk("reload_done", {done, cpu_hold, error}, 3'b100);
        tick();
        chk("reload_wr_count", wr_n - wr_base, 8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
